// File: rtl/align16_prenorm.sv
// align16_prenorm: fp16 adder pre-normalisation stage.
// Unpacks, orders by magnitude, iteratively aligns the smaller significand.

module align16_prenorm #(
    parameter int SHIFT_STEP = 1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_A,
    input  logic [15:0] IN_B,
    input  logic        IN_SUB,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        SIGN_A,
    output logic        SIGN_B,
    output logic [4:0]  OUT_EXP_HALF,
    output logic [10:0] OUT_MANT_A_HALF,
    output logic [10:0] OUT_MANT_B_HALF,
    output logic        STICKY_BIT,
    output logic        EFF_SUB,
    output logic        SPECIAL,
    output logic [15:0] SPECIAL_Q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    logic [1:0]  state_q, state_d;
    logic        rdy_en_q;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [4:0]  exp_q, exp_d;
    logic [10:0] mant_a_q, mant_a_d;
    logic [10:0] mant_b_q, mant_b_d;
    logic        sticky_q, sticky_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        spec_q, spec_d;
    logic [15:0] spec_val_q, spec_val_d;

    logic        accept;
    logic        load;

    logic        ua_sign, ub_sign;
    logic [4:0]  ua_exp, ub_exp;
    logic [10:0] ua_sig, ub_sig;
    logic        ua_max, ub_max;
    logic        ua_inf, ub_inf;
    logic        ua_nan, ub_nan;
    logic        swap;
    logic        big_sign, small_sign;
    logic [4:0]  big_exp, small_exp;
    logic [10:0] big_sig, small_sig;
    logic [4:0]  diff;
    logic        spec_hit;
    logic [15:0] spec_val;

    logic [4:0]  sh;
    logic [10:0] sh_mask;
    logic [10:0] sh_mant;
    logic        sh_lost;
    logic [4:0]  sh_cnt;

    // Handshake: ready only once reset has been seen released.
    assign accept = IN_VALID & IN_READY;
    assign IN_READY = rdy_en_q &
                      ((state_q == S_IDLE) |
                       ((state_q == S_DONE) & OUT_READY));
    assign OUT_VALID = (state_q == S_DONE);

    // Unpack; subnormals/zero use effective exponent 1, no hidden bit.
    assign ua_sign = IN_A[15];
    assign ub_sign = IN_B[15] ^ IN_SUB;
    assign ua_max  = (IN_A[14:10] == 5'h1F);
    assign ub_max  = (IN_B[14:10] == 5'h1F);
    assign ua_inf  = ua_max & (IN_A[9:0] == 10'd0);
    assign ub_inf  = ub_max & (IN_B[9:0] == 10'd0);
    assign ua_nan  = ua_max & (IN_A[9:0] != 10'd0);
    assign ub_nan  = ub_max & (IN_B[9:0] != 10'd0);

    assign ua_exp = (IN_A[14:10] == 5'd0) ? 5'd1 : IN_A[14:10];
    assign ub_exp = (IN_B[14:10] == 5'd0) ? 5'd1 : IN_B[14:10];
    assign ua_sig = {IN_A[14:10] != 5'd0, IN_A[9:0]};
    assign ub_sig = {IN_B[14:10] != 5'd0, IN_B[9:0]};

    // Order by magnitude; a tie keeps A in front.
    assign swap = {ub_exp, ub_sig} > {ua_exp, ua_sig};

    assign big_sign   = swap ? ub_sign : ua_sign;
    assign small_sign = swap ? ua_sign : ub_sign;
    assign big_exp    = swap ? ub_exp  : ua_exp;
    assign small_exp  = swap ? ua_exp  : ub_exp;
    assign big_sig    = swap ? ub_sig  : ua_sig;
    assign small_sig  = swap ? ua_sig  : ub_sig;
    assign diff       = big_exp - small_exp;

    // Resolve NaN/Inf combinations to a packed result.
    always_comb begin
        spec_hit = ua_nan | ub_nan | ua_inf | ub_inf;
        spec_val = 16'h0000;
        if (ua_nan | ub_nan) begin
            spec_val = 16'h7E00;
        end else if (ua_inf & ub_inf & (ua_sign ^ ub_sign)) begin
            spec_val = 16'h7E00;
        end else if (ua_inf) begin
            spec_val = {ua_sign, 5'h1F, 10'h000};
        end else if (ub_inf) begin
            spec_val = {ub_sign, 5'h1F, 10'h000};
        end
    end

    // One alignment step: shift by min(STEP, remaining count).
    assign sh      = (cnt_q < STEP) ? cnt_q : STEP;
    assign sh_mask = (11'd1 << sh) - 11'd1;
    assign sh_mant = mant_b_q >> sh;
    assign sh_lost = |(mant_b_q & sh_mask);
    assign sh_cnt  = cnt_q - sh;

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        exp_d      = exp_q;
        mant_a_d   = mant_a_q;
        mant_b_d   = mant_b_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        load       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                mant_b_d = sh_mant;
                sticky_d = sticky_q | sh_lost;
                cnt_d    = sh_cnt;
                if ((sh_cnt == 5'd0) ||
                    (EARLY_EXIT && (sh_mant == 11'd0))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            sign_a_d   = big_sign;
            sign_b_d   = small_sign;
            sticky_d   = 1'b0;
            spec_d     = spec_hit;
            spec_val_d = spec_val;
            if (spec_hit) begin
                exp_d    = 5'd0;
                mant_a_d = 11'd0;
                mant_b_d = 11'd0;
                cnt_d    = 5'd0;
                state_d  = S_DONE;
            end else begin
                exp_d    = big_exp;
                mant_a_d = big_sig;
                mant_b_d = small_sig;
                cnt_d    = diff;
                state_d  = (diff == 5'd0) ? S_DONE : S_SHIFT;
            end
        end
    end

    // State and result registers; reset aborts any work in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            rdy_en_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            exp_q      <= 5'd0;
            mant_a_q   <= 11'd0;
            mant_b_q   <= 11'd0;
            sticky_q   <= 1'b0;
            cnt_q      <= 5'd0;
            spec_q     <= 1'b0;
            spec_val_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            exp_q      <= exp_d;
            mant_a_q   <= mant_a_d;
            mant_b_q   <= mant_b_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
        end
    end

    assign SIGN_A          = sign_a_q;
    assign SIGN_B          = sign_b_q;
    assign EFF_SUB         = sign_a_q ^ sign_b_q;
    assign OUT_EXP_HALF    = exp_q;
    assign OUT_MANT_A_HALF = mant_a_q;
    assign OUT_MANT_B_HALF = mant_b_q;
    assign STICKY_BIT      = sticky_q;
    assign SPECIAL         = spec_q;
    assign SPECIAL_Q       = spec_val_q;

endmodule

// File: tb/tb_align16_prenorm.sv
// tb_align16_prenorm: directed table, corner sequences and random
// operands against an arithmetic model, on two parameterisations.

module tb_align16_prenorm;

    typedef struct {
        logic        sa;
        logic        sb;
        logic        es;
        logic        sp;
        logic        st;
        logic        chk_sign;
        logic [4:0]  e;
        logic [10:0] ma;
        logic [10:0] mb;
        logic [15:0] q;
        int          lat;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid[2];
    logic        in_sub[2];
    logic        out_ready[2];
    logic [15:0] in_a[2];
    logic [15:0] in_b[2];

    logic        in_ready[2];
    logic        out_valid[2];
    logic        sign_a[2];
    logic        sign_b[2];
    logic        eff_sub[2];
    logic        sticky[2];
    logic        special[2];
    logic [4:0]  oexp[2];
    logic [10:0] ma[2];
    logic [10:0] mb[2];
    logic [15:0] sq[2];

    int n_cmp = 0;
    int n_err = 0;

    int step_cfg[2] = '{1, 4};
    bit ee_cfg[2]   = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    align16_prenorm #(.SHIFT_STEP(1), .EARLY_EXIT(1'b1)) u_dut0 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .IN_A(in_a[0]), .IN_B(in_b[0]), .IN_SUB(in_sub[0]),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .SIGN_A(sign_a[0]), .SIGN_B(sign_b[0]),
        .OUT_EXP_HALF(oexp[0]),
        .OUT_MANT_A_HALF(ma[0]), .OUT_MANT_B_HALF(mb[0]),
        .STICKY_BIT(sticky[0]), .EFF_SUB(eff_sub[0]),
        .SPECIAL(special[0]), .SPECIAL_Q(sq[0])
    );

    align16_prenorm #(.SHIFT_STEP(4), .EARLY_EXIT(1'b0)) u_dut1 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .IN_A(in_a[1]), .IN_B(in_b[1]), .IN_SUB(in_sub[1]),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .SIGN_A(sign_a[1]), .SIGN_B(sign_b[1]),
        .OUT_EXP_HALF(oexp[1]),
        .OUT_MANT_A_HALF(ma[1]), .OUT_MANT_B_HALF(mb[1]),
        .STICKY_BIT(sticky[1]), .EFF_SUB(eff_sub[1]),
        .SPECIAL(special[1]), .SPECIAL_Q(sq[1])
    );

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: IEEE-style rules with plain integer arithmetic.
    function automatic res_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic sub,
                                   input int step, input bit ee);
        res_t r;
        int ea, eb, ga, gb, diff, k, s, t;
        logic sa, sb, tl;
        bit nan_a, nan_b, inf_a, inf_b, fin;
        r = '{default: 0};
        sa = a[15];
        sb = b[15] ^ sub;
        nan_a = (a[14:10] == 31) && (a[9:0] != 0);
        nan_b = (b[14:10] == 31) && (b[9:0] != 0);
        inf_a = (a[14:10] == 31) && (a[9:0] == 0);
        inf_b = (b[14:10] == 31) && (b[9:0] == 0);
        if (nan_a || nan_b || inf_a || inf_b) begin
            r.sp = 1'b1;
            r.lat = 1;
            if (nan_a || nan_b) r.q = 16'h7E00;
            else if (inf_a && inf_b && (sa != sb)) r.q = 16'h7E00;
            else if (inf_a) r.q = {sa, 15'h7C00};
            else r.q = {sb, 15'h7C00};
            return r;
        end
        ea = (a[14:10] == 0) ? 1 : int'(a[14:10]);
        eb = (b[14:10] == 0) ? 1 : int'(b[14:10]);
        ga = (a[14:10] == 0) ? int'(a[9:0]) : 1024 + int'(a[9:0]);
        gb = (b[14:10] == 0) ? int'(b[9:0]) : 1024 + int'(b[9:0]);
        if (eb * 2048 + gb > ea * 2048 + ga) begin
            t = ea; ea = eb; eb = t;
            t = ga; ga = gb; gb = t;
            tl = sa; sa = sb; sb = tl;
        end
        diff = ea - eb;
        r.chk_sign = 1'b1;
        r.sa = sa;
        r.sb = sb;
        r.es = sa ^ sb;
        r.e = 5'(ea);
        r.ma = 11'(ga);
        r.mb = 11'(gb >> diff);
        r.st = (gb % (1 << diff)) != 0;
        if (diff == 0) begin
            r.lat = 1;
        end else begin
            k = 0;
            fin = 0;
            while (!fin) begin
                k++;
                s = (k * step < diff) ? k * step : diff;
                if (s == diff || (ee && (gb >> s) == 0)) fin = 1;
            end
            r.lat = 1 + k;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic sub, input logic sa,
                                input logic sb, input logic sp,
                                input logic st, input int e,
                                input int m_a, input int m_b,
                                input logic [15:0] q, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub;
        v.r = '{default: 0};
        v.r.sa = sa; v.r.sb = sb; v.r.es = sa ^ sb;
        v.r.sp = sp; v.r.st = st; v.r.chk_sign = !sp;
        v.r.e = 5'(e); v.r.ma = 11'(m_a); v.r.mb = 11'(m_b);
        v.r.q = q; v.r.lat = lat;
        return v;
    endfunction

    function automatic logic [15:0] rnd_fp(input int near, input bit use_near);
        logic [15:0] v;
        int e;
        v = 16'($urandom);
        if ($urandom_range(0, 15) == 0) e = 31;
        else if (use_near) begin
            e = near + int'($urandom_range(0, 6)) - 3;
            if (e < 0) e = 0;
            if (e > 30) e = 30;
        end else e = $urandom_range(0, 30);
        if ($urandom_range(0, 7) == 0) v[9:0] = 10'd0;
        v[14:10] = 5'(e);
        return v;
    endfunction

    // Called at a negedge; returns at the first negedge after accept.
    task automatic issue(input int idx, input logic [15:0] a,
                         input logic [15:0] b, input logic sub);
        int w;
        w = 0;
        while (!in_ready[idx] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_issue", int'(in_ready[idx]), 1);
        in_valid[idx] = 1'b1;
        in_a[idx] = a;
        in_b[idx] = b;
        in_sub[idx] = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        out_ready[idx] = 1'b0;
        in_a[idx] = 16'($urandom);
        in_b[idx] = 16'($urandom);
        in_sub[idx] = 1'($urandom);
    endtask

    task automatic cmp_out(input int idx, input res_t r, input string tag);
        chk({tag, " exp"}, int'(oexp[idx]), int'(r.e));
        chk({tag, " mant_a"}, int'(ma[idx]), int'(r.ma));
        chk({tag, " mant_b"}, int'(mb[idx]), int'(r.mb));
        chk({tag, " sticky"}, int'(sticky[idx]), int'(r.st));
        chk({tag, " special"}, int'(special[idx]), int'(r.sp));
        if (r.sp) chk({tag, " special_q"}, int'(sq[idx]), int'(r.q));
        if (r.chk_sign) begin
            chk({tag, " sign_a"}, int'(sign_a[idx]), int'(r.sa));
            chk({tag, " sign_b"}, int'(sign_b[idx]), int'(r.sb));
            chk({tag, " eff_sub"}, int'(eff_sub[idx]), int'(r.es));
        end
    endtask

    task automatic wait_check(input int idx, input res_t r, input string tag);
        int lat;
        lat = 1;
        while (!out_valid[idx] && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " out_valid"}, int'(out_valid[idx]), 1);
        chk({tag, " latency"}, lat, r.lat);
        if (out_valid[idx]) cmp_out(idx, r, tag);
    endtask

    task automatic pop(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[idx] = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        res_t r;
        res_t r2;
        logic [15:0] ra, rb;
        logic rs;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_sub[i] = 1'b0;
            out_ready[i] = 1'b0;
            in_a[i] = 16'h0;
            in_b[i] = 16'h0;
        end

        tbl.push_back(mk(16'h3C00, 16'h3C00, 0, 0, 0, 0, 0, 15, 'h400, 'h400, 0, 1));
        tbl.push_back(mk(16'h3C00, 16'h3400, 0, 0, 0, 0, 0, 15, 'h400, 'h100, 0, 3));
        tbl.push_back(mk(16'h3400, 16'h4000, 1, 1, 0, 0, 0, 16, 'h400, 'h080, 0, 4));
        tbl.push_back(mk(16'h6400, 16'h3C01, 0, 0, 0, 0, 1, 25, 'h400, 'h001, 0, 11));
        tbl.push_back(mk(16'h6400, 16'h0001, 0, 0, 0, 0, 1, 25, 'h400, 'h000, 0, 2));
        tbl.push_back(mk(16'h7C00, 16'hFC00, 0, 0, 0, 1, 0, 0, 0, 0, 16'h7E00, 1));
        tbl.push_back(mk(16'h7E00, 16'h3C00, 0, 0, 0, 1, 0, 0, 0, 0, 16'h7E00, 1));
        tbl.push_back(mk(16'h7C00, 16'h3C00, 1, 0, 0, 1, 0, 0, 0, 0, 16'h7C00, 1));
        tbl.push_back(mk(16'h3C00, 16'hFC00, 1, 0, 0, 1, 0, 0, 0, 0, 16'h7C00, 1));
        tbl.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 1, 0, 0, 15, 'h400, 'h400, 0, 1));
        tbl.push_back(mk(16'h3C00, 16'h3C01, 0, 0, 0, 0, 0, 15, 'h401, 'h400, 0, 1));

        // Reset state.
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst in_ready", int'(in_ready[i]), 0);
            chk("rst out_valid", int'(out_valid[i]), 0);
            chk("rst mant_a", int'(ma[i]), 0);
            chk("rst mant_b", int'(mb[i]), 0);
            chk("rst special", int'(special[i]), 0);
            chk("rst eff_sub", int'(eff_sub[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", int'(in_ready[0]), 1);

        // Directed table on the STEP=1 / early-exit instance.
        foreach (tbl[i]) begin
            issue(0, tbl[i].a, tbl[i].b, tbl[i].sub);
            wait_check(0, tbl[i].r, $sformatf("tbl%0d", i));
            pop(0);
        end

        // Stall: outputs frozen and no acceptance while OUT_READY=0.
        r = model(16'h3C00, 16'h3400, 1'b0, 1, 1'b1);
        issue(0, 16'h3C00, 16'h3400, 1'b0);
        wait_check(0, r, "hold");
        in_valid[0] = 1'b1;
        in_a[0] = 16'h4000;
        in_b[0] = 16'h4000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold out_valid", int'(out_valid[0]), 1);
            chk("hold in_ready", int'(in_ready[0]), 0);
            cmp_out(0, r, "hold");
        end
        in_valid[0] = 1'b0;
        pop(0);

        // Zero-bubble handoff from DONE.
        r = model(16'h3C00, 16'h3800, 1'b0, 1, 1'b1);
        r2 = model(16'h5000, 16'hC400, 1'b1, 1, 1'b1);
        issue(0, 16'h3C00, 16'h3800, 1'b0);
        wait_check(0, r, "b2b first");
        out_ready[0] = 1'b1;
        issue(0, 16'h5000, 16'hC400, 1'b1);
        wait_check(0, r2, "b2b second");
        pop(0);

        // Reset asserted mid-shift.
        issue(0, 16'h6400, 16'h3C01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid[0]), 0);
        chk("midrst in_ready", int'(in_ready[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst ready after release", int'(in_ready[0]), 1);
        for (int c = 0; c < 12; c++) @(negedge clk);
        chk("midrst no result", int'(out_valid[0]), 0);

        // Random operands against the model on both instances.
        for (int idx = 0; idx < 2; idx++) begin
            ra = rnd_fp(0, 0);
            rb = rnd_fp(int'(ra[14:10]), 1);
            rs = 1'($urandom);
            r = model(ra, rb, rs, step_cfg[idx], ee_cfg[idx]);
            issue(idx, ra, rb, rs);
            wait_check(idx, r, $sformatf("rnd%0d_0", idx));
            for (int n = 1; n < 200; n++) begin
                ra = rnd_fp(0, 0);
                rb = rnd_fp(int'(ra[14:10]), $urandom_range(0, 1) == 1);
                rs = 1'($urandom);
                r = model(ra, rb, rs, step_cfg[idx], ee_cfg[idx]);
                if ($urandom_range(0, 2) == 0) begin
                    out_ready[idx] = 1'b1;
                end else begin
                    for (int w = $urandom_range(0, 2); w > 0; w--)
                        @(negedge clk);
                    pop(idx);
                end
                issue(idx, ra, rb, rs);
                wait_check(idx, r, $sformatf("rnd%0d_%0d a=%h b=%h s=%0d",
                                             idx, n, ra, rb, rs));
            end
            pop(idx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
